// File: rtl/enc_sequencer_if.sv
// enc_sequencer beat interface toward enc_selector.
// Per-beat phase, symbol requests and parity release.
interface enc_sequencer_if #(
  parameter int SYM = 8
) ();
  localparam int RQ_W = $clog2(SYM + 1);

  logic            gen_valid;
  logic [1:0]      sel_phase;
  logic [RQ_W-1:0] mes_request;
  logic [RQ_W-1:0] par_request;
  logic            par_release;

  modport master (
    output gen_valid,
    output sel_phase,
    output mes_request,
    output par_request,
    output par_release
  );

  modport slave (
    input gen_valid,
    input sel_phase,
    input mes_request,
    input par_request,
    input par_release
  );
endinterface

// File: rtl/enc_sequencer.sv
// enc_sequencer: RS codeword beat sequencer.
// Picks message/parity/straddle phase per beat.
module enc_sequencer #(
  parameter int SYM       = 8,
  parameter int MES_LEN   = 223,
  parameter int PAR_LEN   = 32,
  parameter int MES_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [MES_CNT_W-1:0] mes_count,
  input  logic                 par_ready,
  enc_sequencer_if.master      beat,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [15:0]          cw_count
);
  localparam int N    = MES_LEN + PAR_LEN;
  localparam int E_W  = $clog2(N + SYM);
  localparam int RQ_W = $clog2(SYM + 1);

  localparam logic [E_W-1:0] K_V = E_W'(MES_LEN);
  localparam logic [E_W-1:0] N_V = E_W'(N);
  localparam logic [E_W-1:0] S_V = E_W'(SYM);

  localparam logic [1:0] SEL_MES = 2'd0;
  localparam logic [1:0] SEL_PAR = 2'd1;
  localparam logic [1:0] SEL_MTP = 2'd2;
  localparam logic [1:0] SEL_PTM = 2'd3;

  logic [E_W-1:0]  pos;
  logic [E_W-1:0]  e;
  logic [E_W-1:0]  pos_nxt;
  logic [1:0]      phase;
  logic [RQ_W-1:0] mes_req;
  logic [RQ_W-1:0] par_req;
  logic            gv;
  logic            rel;
  logic            sop;

  // Phase decode, issue qualification and next position
  always_comb begin
    e       = pos + S_V;
    phase   = SEL_MES;
    mes_req = RQ_W'(SYM);
    par_req = '0;
    unique case (1'b1)
      (e <= K_V): begin
        phase = SEL_MES;
      end
      (pos < K_V && e > K_V): begin
        phase   = SEL_MTP;
        mes_req = RQ_W'(K_V - pos);
        par_req = RQ_W'(e - K_V);
      end
      (pos >= K_V && e <= N_V): begin
        phase   = SEL_PAR;
        mes_req = '0;
        par_req = RQ_W'(SYM);
      end
      default: begin
        phase   = SEL_PTM;
        par_req = RQ_W'(N_V - pos);
        mes_req = RQ_W'(e - N_V);
      end
    endcase
    gv = enable & ~clear
       & (mes_count >= MES_CNT_W'(mes_req))
       & ((par_req == '0) | par_ready);
    rel = gv & ((phase == SEL_PTM)
        | ((phase == SEL_PAR) & (e == N_V)));
    sop = gv & (((phase == SEL_MES) & (pos == '0))
        | (phase == SEL_PTM));
    pos_nxt = (e < N_V) ? e : e - N_V;
  end

  assign beat.gen_valid   = gv;
  assign beat.sel_phase   = phase;
  assign beat.mes_request = mes_req;
  assign beat.par_request = par_req;
  assign beat.par_release = rel;

  // Position, output-aligned flags and codeword counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      cw_count  <= '0;
    end else begin
      if (clear)
        pos <= '0;
      else if (gv)
        pos <= pos_nxt;
      out_valid <= gv;
      out_sop   <= sop;
      out_eop   <= rel;
      if (rel)
        cw_count <= cw_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_enc_sequencer.sv
// tb_enc_sequencer: directed checks for enc_sequencer.
// K=223, P=32, SYM=8.
module tb_enc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        par_ready = 1'b0;
  logic [7:0]  mes_count = 8'd0;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] cw_count;

  int checks = 0;
  int errors = 0;
  int o_gv, o_ph, o_mr, o_pr;
  int sum_m, sum_p, n_sop, n_eop;

  enc_sequencer_if #(.SYM(8)) beat ();

  enc_sequencer #(
    .SYM(8),
    .MES_LEN(223),
    .PAR_LEN(32),
    .MES_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clear(clear),
    .mes_count(mes_count),
    .par_ready(par_ready),
    .beat(beat),
    .out_valid(out_valid),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    #1;
    o_gv = int'(beat.gen_valid);
    o_ph = int'(beat.sel_phase);
    o_mr = int'(beat.mes_request);
    o_pr = int'(beat.par_request);
    if (beat.gen_valid) begin
      sum_m += int'(beat.mes_request);
      sum_p += int'(beat.par_request);
    end
    @(posedge clk);
    #1;
    if (out_sop) n_sop++;
    if (out_eop) n_eop++;
    @(negedge clk);
  endtask

  task automatic beat_chk(input string tag, input int ph,
                          input int mr, input int pr);
    chk({tag, ".ph"}, o_ph, ph);
    chk({tag, ".mr"}, o_mr, mr);
    chk({tag, ".pr"}, o_pr, pr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sum_m = 0;
    sum_p = 0;
    n_sop = 0;
    n_eop = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst.ov", int'(out_valid), 0);
    chk("rst.sop", int'(out_sop), 0);
    chk("rst.eop", int'(out_eop), 0);
    chk("rst.cw", int'(cw_count), 0);
    chk("rst.ph", int'(beat.sel_phase), 0);
    chk("rst.mr", int'(beat.mes_request), 8);

    enable = 1'b1;
    mes_count = 8'd255;
    par_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      chk("t1.gv", o_gv, 1);
      if (i < 27) beat_chk("t1.mes", 0, 8, 0);
      else if (i == 27) beat_chk("t1.mtp", 2, 7, 1);
      else if (i < 31) beat_chk("t1.par", 1, 0, 8);
      else beat_chk("t1.ptm", 3, 1, 7);
      chk("t1.eop", int'(out_eop), (i == 31) ? 1 : 0);
      chk("t1.sop", int'(out_sop), (i == 0 || i == 31) ? 1 : 0);
    end
    chk("t1.cw", int'(cw_count), 1);
    chk("t1.neop", n_eop, 1);
    repeat (27) cyc();
    cyc();
    beat_chk("t1.pos1", 2, 6, 2);

    clear = 1'b1;
    cyc();
    chk("t5.realign.gv", o_gv, 0);
    chk("t5.realign.ov", int'(out_valid), 0);
    clear = 1'b0;
    repeat (29) cyc();
    clear = 1'b1;
    cyc();
    chk("t5.gv", o_gv, 0);
    beat_chk("t5.p232", 1, 0, 8);
    chk("t5.ov", int'(out_valid), 0);
    chk("t5.sop", int'(out_sop), 0);
    chk("t5.cw", int'(cw_count), 1);
    clear = 1'b0;
    cyc();
    chk("t5.next.gv", o_gv, 1);
    beat_chk("t5.next", 0, 8, 0);
    chk("t5.next.sop", int'(out_sop), 1);
    chk("t5.next.cw", int'(cw_count), 1);

    repeat (27) cyc();
    cyc();
    beat_chk("t6.par", 1, 0, 8);
    chk("t6.pre.ov", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.ov", int'(out_valid), 0);
    chk("t6.sop", int'(out_sop), 0);
    chk("t6.eop", int'(out_eop), 0);
    chk("t6.cw", int'(cw_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t6.first.gv", o_gv, 1);
    beat_chk("t6.first", 0, 8, 0);
    chk("t6.first.sop", int'(out_sop), 1);

    repeat (26) cyc();
    par_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3.stall.gv", o_gv, 0);
      beat_chk("t3.stall", 2, 7, 1);
      chk("t3.stall.ov", int'(out_valid), 0);
    end
    par_ready = 1'b1;
    cyc();
    chk("t3.go.gv", o_gv, 1);
    beat_chk("t3.go", 2, 7, 1);
    chk("t3.go.ov", int'(out_valid), 1);
    cyc();
    beat_chk("t3.p224", 1, 0, 8);

    do_reset();
    mes_count = 8'd3;
    cyc();
    chk("t4.m3.gv", o_gv, 0);
    chk("t4.m3.ov", int'(out_valid), 0);
    mes_count = 8'd7;
    cyc();
    chk("t4.m7.gv", o_gv, 0);
    mes_count = 8'd8;
    cyc();
    chk("t4.m8.gv", o_gv, 1);
    beat_chk("t4.m8", 0, 8, 0);
    chk("t4.m8.sop", int'(out_sop), 1);

    do_reset();
    mes_count = 8'd255;
    for (int i = 0; i < 8160; i++) begin
      cyc();
      if (i == 255) begin
        chk("t2.wrap.ph", o_ph, 0);
        chk("t2.wrap.sop", int'(out_sop), 1);
      end
    end
    chk("t2.cw", int'(cw_count), 256);
    chk("t2.sum_m", sum_m, 223 * 256);
    chk("t2.sum_p", sum_p, 32 * 256);
    chk("t2.nsop", n_sop, 256);
    chk("t2.neop", n_eop, 256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
